demux_1to4_reg: RTL and testbench

DEMUX_1TO4_REG -- requirements
Module: demux_1to4_reg

---
 rtl/demux_1to4_reg.sv | 65 ++++++
 tb/tb_demux_1to4_reg.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/demux_1to4_reg.sv
// Registered 1-to-4 demultiplexer with per-channel valid/ready output slots.
// The target channel comes from sel or from a round-robin pointer that advances per routed word.
module demux_1to4_reg #(
   parameter int width = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [width-1:0] i,
   input  logic [1:0]       sel,
   input  logic             auto,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [width-1:0] o0,
   output logic [width-1:0] o1,
   output logic [width-1:0] o2,
   output logic [width-1:0] o3,
   output logic [3:0]       o_valid,
   input  logic [3:0]       o_ready,
   output logic [1:0]       next_ch
);

   // Handshake: a word moves on a cycle where valid and ready are both high at the
   // rising edge. Ready never looks at valid, and a valid word is held unchanged until it moves.
   logic [width-1:0] data_q [4];
   logic [3:0]       valid_q;
   logic [1:0]       rr_ptr;
   logic [1:0]       tgt;
   logic             accept;
   logic [3:0]       load;

   always_comb begin
      tgt      = auto ? rr_ptr : sel;
      in_ready = !valid_q[tgt] | o_ready[tgt];
      accept   = in_valid & in_ready;
      load     = 4'b0000;
      if (accept) load = 4'b0001 << tgt;
   end

   // A load wins over a drain on the same channel, so the slot stays full with the new word.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < 4; k++) data_q[k] <= '0;
         valid_q <= 4'b0000;
         rr_ptr  <= 2'd0;
      end else begin
         for (int k = 0; k < 4; k++) begin
            if (load[k]) begin
               data_q[k]  <= i;
               valid_q[k] <= 1'b1;
            end else if (valid_q[k] && o_ready[k]) begin
               valid_q[k] <= 1'b0;
            end
         end
         if (accept && auto) rr_ptr <= rr_ptr + 2'd1;
      end
   end

   assign o0      = data_q[0];
   assign o1      = data_q[1];
   assign o2      = data_q[2];
   assign o3      = data_q[3];
   assign o_valid = valid_q;
   assign next_ch = rr_ptr;

endmodule

// File: tb/tb_demux_1to4_reg.sv
// Bench for demux_1to4_reg: vector table plus hand-written reset and mode-switch sequences,
// with a scoreboard of {channel, data} entries retired when a channel hands a word downstream.
module tb_demux_1to4_reg;
   localparam int W = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [W-1:0]  i;
   logic [1:0]    sel;
   logic          auto;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  o0, o1, o2, o3;
   logic [3:0]    o_valid;
   logic [3:0]    o_ready;
   logic [1:0]    next_ch;

   demux_1to4_reg #(.width(W)) dut (
      .clk(clk), .rst_n(rst_n), .i(i), .sel(sel), .auto(auto),
      .in_valid(in_valid), .in_ready(in_ready),
      .o0(o0), .o1(o1), .o2(o2), .o3(o3),
      .o_valid(o_valid), .o_ready(o_ready), .next_ch(next_ch)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic         v;
      logic         au;
      logic [1:0]   sel;
      logic [W-1:0] d;
      logic [3:0]   ord;
      logic         rdy;
      logic [1:0]   ch;
      logic [3:0]   ov;
      logic [1:0]   nc;
   } vec_t;

   int            checks = 0;
   int            errors = 0;
   logic [W+1:0]  exp_q[$];
   vec_t          tbl[$];

   function automatic vec_t mk(logic v, logic au, logic [1:0] s, logic [W-1:0] d,
                               logic [3:0] ord, logic rdy, logic [1:0] ch,
                               logic [3:0] ov, logic [1:0] nc);
      vec_t r;
      r.v = v; r.au = au; r.sel = s; r.d = d; r.ord = ord;
      r.rdy = rdy; r.ch = ch; r.ov = ov; r.nc = nc;
      return r;
   endfunction

   function automatic logic [W-1:0] out_of(int k);
      case (k)
         0: return o0;
         1: return o1;
         2: return o2;
         default: return o3;
      endcase
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic reset_checks(input string tag);
      check({tag, " o_valid"}, 32'(o_valid), 32'h0);
      check({tag, " next_ch"}, 32'(next_ch), 32'h0);
      check({tag, " in_ready"}, 32'(in_ready), 32'h1);
      check({tag, " o0"}, 32'(o0), 32'h0);
      check({tag, " o1"}, 32'(o1), 32'h0);
      check({tag, " o2"}, 32'(o2), 32'h0);
      check({tag, " o3"}, 32'(o3), 32'h0);
   endtask

   // Drive one cycle's inputs, check ready, retire deliveries, then queue the accepted word.
   task automatic drive_pre(input string tag, input vec_t v);
      int idx;
      in_valid = v.v; auto = v.au; sel = v.sel; i = v.d; o_ready = v.ord;
      #1;
      check({tag, " in_ready"}, 32'(in_ready), 32'(v.rdy));
      for (int k = 0; k < 4; k++) begin
         if (o_valid[k] && o_ready[k]) begin
            idx = -1;
            for (int j = 0; j < exp_q.size(); j++)
               if (idx < 0 && int'(exp_q[j][W+1:W]) == k) idx = j;
            checks++;
            if (idx < 0) begin
               errors++;
               $display("FAIL %s unexpected delivery: ch%0d data %0h, none expected", tag, k, out_of(k));
            end else begin
               if (out_of(k) !== exp_q[idx][W-1:0]) begin
                  errors++;
                  $display("FAIL %s ch%0d data: got %0h expected %0h", tag, k, out_of(k), exp_q[idx][W-1:0]);
               end
               exp_q.delete(idx);
            end
         end
      end
      if (v.v && v.rdy) exp_q.push_back({v.ch, v.d});
   endtask

   task automatic post(input string tag, input vec_t v);
      @(posedge clk);
      #1;
      check({tag, " o_valid"}, 32'(o_valid), 32'(v.ov));
      check({tag, " next_ch"}, 32'(next_ch), 32'(v.nc));
   endtask

   task automatic step(input string tag, input vec_t v);
      @(negedge clk);
      drive_pre(tag, v);
      post(tag, v);
   endtask

   initial begin
      in_valid = 1'b1; auto = 1'b1; sel = 2'd0; i = 4'hF; o_ready = 4'b0000;
      repeat (2) @(posedge clk);
      #1;
      reset_checks("reset");

      // Explicit routing, all channels draining.
      tbl.push_back(mk(1, 0, 0, 4'hA, 4'hF, 1, 0, 4'b0001, 0));
      tbl.push_back(mk(1, 0, 1, 4'hB, 4'hF, 1, 1, 4'b0010, 0));
      tbl.push_back(mk(1, 0, 2, 4'hC, 4'hF, 1, 2, 4'b0100, 0));
      tbl.push_back(mk(1, 0, 3, 4'hD, 4'hF, 1, 3, 4'b1000, 0));
      tbl.push_back(mk(0, 0, 0, 4'h0, 4'hF, 1, 0, 4'b0000, 0));
      // Round-robin with wrap.
      tbl.push_back(mk(1, 1, 0, 4'h1, 4'hF, 1, 0, 4'b0001, 1));
      tbl.push_back(mk(1, 1, 0, 4'h2, 4'hF, 1, 1, 4'b0010, 2));
      tbl.push_back(mk(1, 1, 0, 4'h3, 4'hF, 1, 2, 4'b0100, 3));
      tbl.push_back(mk(1, 1, 0, 4'h4, 4'hF, 1, 3, 4'b1000, 0));
      tbl.push_back(mk(1, 1, 0, 4'h5, 4'hF, 1, 0, 4'b0001, 1));
      tbl.push_back(mk(0, 0, 0, 4'h0, 4'hF, 1, 0, 4'b0000, 1));
      // Backpressure on channel 2, then load-over-drain.
      tbl.push_back(mk(1, 0, 2, 4'hC, 4'h0, 1, 2, 4'b0100, 1));
      tbl.push_back(mk(1, 0, 2, 4'hD, 4'h0, 0, 2, 4'b0100, 1));
      tbl.push_back(mk(1, 0, 2, 4'hD, 4'h4, 1, 2, 4'b0100, 1));
      tbl.push_back(mk(0, 0, 2, 4'h0, 4'h4, 1, 2, 4'b0000, 1));
      // Channel 1 stalled while channel 3 takes a word.
      tbl.push_back(mk(1, 0, 1, 4'hB, 4'h0, 1, 1, 4'b0010, 1));
      tbl.push_back(mk(1, 0, 1, 4'h7, 4'h0, 0, 1, 4'b0010, 1));
      tbl.push_back(mk(1, 0, 3, 4'hE, 4'h8, 1, 3, 4'b1010, 1));
      tbl.push_back(mk(0, 0, 3, 4'h0, 4'h8, 1, 3, 4'b0010, 1));
      tbl.push_back(mk(0, 0, 1, 4'h0, 4'h2, 1, 1, 4'b0000, 1));

      @(negedge clk);
      in_valid = 1'b0;
      rst_n = 1'b1;
      for (int n = 0; n < tbl.size(); n++) step($sformatf("vec%0d", n), tbl[n]);

      // Unknown data and select with no valid word must leave state alone.
      @(negedge clk);
      in_valid = 1'b0; auto = 1'b0; sel = 2'bxx; i = 'x; o_ready = 4'b0000;
      @(posedge clk);
      #1;
      check("xin o_valid", 32'(o_valid), 32'h0);
      check("xin next_ch", 32'(next_ch), 32'h1);

      // Reset between cycles, then two round-robin accepts and a switch to explicit select.
      @(negedge clk);
      in_valid = 1'b0; sel = 2'd0; i = '0;
      rst_n = 1'b0;
      #1;
      reset_checks("rst2");
      @(negedge clk);
      rst_n = 1'b1;
      step("mode1", mk(1, 1, 0, 4'h1, 4'hF, 1, 0, 4'b0001, 1));
      step("mode2", mk(1, 1, 0, 4'h2, 4'hF, 1, 1, 4'b0010, 2));
      step("mode3", mk(1, 0, 0, 4'h9, 4'h0, 1, 0, 4'b0011, 2));
      step("mode4", mk(1, 0, 3, 4'h3, 4'h0, 1, 3, 4'b1011, 2));

      // Asynchronous reset between edges discards the held words.
      @(negedge clk);
      in_valid = 1'b1; auto = 1'b1;
      #2;
      rst_n = 1'b0;
      #1;
      reset_checks("async_rst");
      exp_q.delete();
      @(posedge clk);
      #1;
      reset_checks("rst_hold");
      @(negedge clk);
      rst_n = 1'b1;
      drive_pre("release", mk(1, 1, 0, 4'h6, 4'hF, 1, 0, 4'b0001, 1));
      post("release", mk(1, 1, 0, 4'h6, 4'hF, 1, 0, 4'b0001, 1));
      step("final", mk(0, 0, 0, 4'h0, 4'hF, 1, 0, 4'b0000, 1));

      check("scoreboard empty", 32'(exp_q.size()), 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
